// File: rtl/rom_scan_reader.sv
// Sweeps a ROM from address 0 to DEPTH-1, streams each (addr, data) word and folds it into a
// 16-bit checksum. Answers at the end whether the checksum matches exp_sum_i.
module rom_scan_reader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [15:0]       exp_sum_i,
  output logic [ADDR_W-1:0] address_o,
  input  logic [DATA_W-1:0] data_i,
  output logic              busy_o,
  output logic              rd_valid_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [15:0]       checksum_o,
  output logic              done_o,
  output logic              pass_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                issue_d;
  logic [RD_LAT:0]     tag_vld_q;
  logic [ADDR_W-1:0]   tag_addr_q [RD_LAT+1];
  logic                rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic [15:0]         checksum_q, checksum_d;
  logic                pass_q, pass_d;
  logic                capture;
  logic                cap_last;
  logic [ADDR_W-1:0]   cap_addr;
  logic [15:0]         sum_next;

  // Stage 0 of the tag pipe travels with the presented address; stage RD_LAT marks the word on data_i.
  assign capture  = tag_vld_q[RD_LAT];
  assign cap_addr = tag_addr_q[RD_LAT];
  assign cap_last = capture && (cap_addr == LAST_ADDR);
  assign sum_next = checksum_q + 16'(data_i);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    issue_d    = 1'b0;
    rd_valid_d = 1'b0;
    rd_addr_d  = rd_addr_q;
    rd_data_d  = rd_data_q;
    checksum_d = checksum_q;
    pass_d     = pass_q;

    if (capture) begin
      rd_valid_d = 1'b1;
      rd_addr_d  = cap_addr;
      rd_data_d  = data_i;
      checksum_d = sum_next;
    end

    unique case (state_q)
      IDLE: begin
        addr_d = '0;
        if (start_i) begin
          state_d    = ISSUE;
          issue_d    = 1'b1;
          checksum_d = '0;
          pass_d     = 1'b0;
        end
      end
      ISSUE: begin
        // With RD_LAT=0 the last word is captured while it is still being presented.
        if (cap_last) begin
          state_d = DONE;
          pass_d  = (sum_next == exp_sum_i);
        end else if (addr_q == LAST_ADDR) begin
          state_d = DRAIN;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          issue_d = 1'b1;
        end
      end
      DRAIN: begin
        if (cap_last) begin
          state_d = DONE;
          pass_d  = (sum_next == exp_sum_i);
        end
      end
      DONE: begin
        state_d = IDLE;
        addr_d  = '0;
      end
      default: begin
        state_d = IDLE;
        addr_d  = '0;
      end
    endcase

    // Abort wins over both start and a word arriving in the same cycle.
    if (abort_i) begin
      state_d    = IDLE;
      addr_d     = '0;
      issue_d    = 1'b0;
      rd_valid_d = 1'b0;
      rd_addr_d  = rd_addr_q;
      rd_data_d  = rd_data_q;
      checksum_d = checksum_q;
      pass_d     = pass_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
      checksum_q <= '0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rd_valid_q <= rd_valid_d;
      rd_addr_q  <= rd_addr_d;
      rd_data_q  <= rd_data_d;
      checksum_q <= checksum_d;
      pass_q     <= pass_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_q <= '0;
      for (int i = 0; i <= RD_LAT; i++) tag_addr_q[i] <= '0;
    end else if (abort_i) begin
      tag_vld_q <= '0;
    end else begin
      tag_vld_q[0]  <= issue_d;
      tag_addr_q[0] <= addr_d;
      for (int i = 1; i <= RD_LAT; i++) begin
        tag_vld_q[i]  <= tag_vld_q[i-1];
        tag_addr_q[i] <= tag_addr_q[i-1];
      end
    end
  end

  assign address_o  = addr_q;
  assign busy_o     = (state_q == ISSUE) || (state_q == DRAIN);
  assign done_o     = (state_q == DONE);
  assign rd_valid_o = rd_valid_q;
  assign rd_addr_o  = rd_addr_q;
  assign rd_data_o  = rd_data_q;
  assign checksum_o = checksum_q;
  assign pass_o     = pass_q;

endmodule
